// File: rtl/snes_pad_poller.sv
// SNES/SFC pad poller: latches two pads on a shared latch/clock pair, shifts in
// 16 bits per pad and publishes both button words (1 = pressed) with a strobe.
module snes_pad_poller #(
  parameter int HALF_CYC = 300,
  parameter int POLL_CYC = 833333
) (
  input  logic        clock,
  input  logic        reset_btn,
  input  logic        poll_now,
  input  logic        p1_data,
  input  logic        p2_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic [15:0] p1_buttons,
  output logic [15:0] p2_buttons,
  output logic        buttons_valid,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_HI = 3'd2,
    CLK_LO = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int PW = $clog2(2 * HALF_CYC);
  localparam int CW = $clog2(POLL_CYC + 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYC - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_CYC - 1);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYC - 1);

  state_t        state, state_n;
  logic [PW-1:0] phase;
  logic [3:0]    idx;
  logic [CW-1:0] poll_cnt;
  logic          poll_tick;
  logic          start;
  logic          p1_s1, p1_s2, p2_s1, p2_s2;
  logic [15:0]   p1_shadow, p2_shadow;

  // Pad data is asynchronous to clock; idle level of an unplugged line is 1.
  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) begin
      p1_s1 <= 1'b1;
      p1_s2 <= 1'b1;
      p2_s1 <= 1'b1;
      p2_s2 <= 1'b1;
    end else begin
      p1_s1 <= p1_data;
      p1_s2 <= p1_s1;
      p2_s1 <= p2_data;
      p2_s2 <= p2_s1;
    end
  end

  assign poll_tick = (poll_cnt == POLL_LAST);
  assign start     = (state == IDLE) && (poll_tick || poll_now);

  // Poll period is measured from the start of the previous poll.
  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) begin
      poll_cnt <= '0;
    end else if (start || poll_tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LATCH;
      LATCH:   if (phase == LATCH_LAST) state_n = CLK_HI;
      CLK_HI:  if (phase == HALF_LAST) state_n = CLK_LO;
      CLK_LO:  if (phase == HALF_LAST) state_n = (idx == 4'd15) ? DONE : CLK_HI;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Phase restarts on every state change and is held at 0 while idle.
  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) begin
      phase <= '0;
    end else if ((state_n != state) || (state == IDLE)) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) begin
      idx <= 4'd0;
    end else if (state == LATCH) begin
      idx <= 4'd0;
    end else if ((state == CLK_LO) && (state_n == CLK_HI)) begin
      idx <= idx + 4'd1;
    end
  end

  // Sample at the end of the high half, furthest from the pad's shift edge.
  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) begin
      p1_shadow <= 16'h0000;
      p2_shadow <= 16'h0000;
    end else if ((state == CLK_HI) && (state_n == CLK_LO)) begin
      p1_shadow[idx] <= ~p1_s2;
      p2_shadow[idx] <= ~p2_s2;
    end
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) begin
      pad_latch     <= 1'b0;
      pad_clk       <= 1'b1;
      buttons_valid <= 1'b0;
      p1_buttons    <= 16'h0000;
      p2_buttons    <= 16'h0000;
    end else begin
      pad_latch     <= (state_n == LATCH);
      pad_clk       <= (state_n != CLK_LO);
      buttons_valid <= (state_n == DONE);
      if (state_n == DONE) begin
        p1_buttons <= p1_shadow;
        p2_buttons <= p2_shadow;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_snes_pad_poller.sv
// Bench for snes_pad_poller: behavioural pads, expected button words queued at
// poll start and compared when buttons_valid strobes.
module tb_snes_pad_poller;
  localparam int HALF = 4;
  localparam int POLL = 200;
  localparam int POLL_LEN = 2 * HALF + 32 * HALF + 1;

  logic        clock = 1'b0;
  logic        reset_btn;
  logic        poll_now;
  logic        p1_data, p2_data;
  logic        pad_latch, pad_clk;
  logic [15:0] p1_buttons, p2_buttons;
  logic        buttons_valid, busy;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_e;

  logic [15:0] word1 = 16'hFFFF, word2 = 16'hFFFF;
  logic [15:0] sr1 = 16'hFFFF, sr2 = 16'hFFFF;
  logic        ovr = 1'b0, ovr_val = 1'b1;
  logic [15:0] prev1 = 16'h0000, prev2 = 16'h0000;

  snes_pad_poller #(.HALF_CYC(HALF), .POLL_CYC(POLL)) dut (
    .clock(clock), .reset_btn(reset_btn), .poll_now(poll_now),
    .p1_data(p1_data), .p2_data(p2_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .p1_buttons(p1_buttons), .p2_buttons(p2_buttons),
    .buttons_valid(buttons_valid), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Pad model: parallel load while latched, shift out LSB first on pad_clk rise.
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) begin
      sr1 = word1;
      sr2 = word2;
    end else begin
      sr1 = {1'b1, sr1[15:1]};
      sr2 = {1'b1, sr2[15:1]};
    end
  end

  assign p1_data = ovr ? ovr_val : sr1[0];
  assign p2_data = sr2[0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_btn && buttons_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check_eq("p1_buttons", 32'(p1_buttons), 32'(exp_e[15:0]));
        check_eq("p2_buttons", 32'(p2_buttons), 32'(exp_e[31:16]));
      end
    end
    if (reset_btn && !buttons_valid && ({p2_buttons, p1_buttons} != {prev2, prev1}))
      check_eq("buttons_stable", {p2_buttons, p1_buttons}, {prev2, prev1});
    prev1 = p1_buttons;
    prev2 = p2_buttons;
  end

  task automatic run_poll(input logic [15:0] w1, input logic [15:0] w2);
    int n, lat, low, falls;
    logic prev_clk;
    word1 = w1;
    word2 = w2;
    exp_q.push_back({~w2, ~w1});
    @(negedge clock) poll_now = 1'b1;
    @(negedge clock) poll_now = 1'b0;
    n = 0; lat = 0; low = 0; falls = 0; prev_clk = 1'b1;
    while (busy && n < 1000) begin
      n++;
      if (pad_latch) lat++;
      if (!pad_clk) low++;
      if (prev_clk && !pad_clk) falls++;
      prev_clk = pad_clk;
      @(negedge clock);
    end
    check_eq("poll_cycles", n, POLL_LEN);
    check_eq("latch_cycles", lat, 2 * HALF);
    check_eq("clk_low_cycles", low, 16 * HALF);
    check_eq("clk_falls", falls, 16);
  endtask

  initial begin
    int n, vc, busy_seen, falls;
    logic [15:0] a, w1, w2;
    logic prev_clk;

    reset_btn = 1'b0;
    poll_now  = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_latch", 32'(pad_latch), 32'd0);
    check_eq("rst_clk", 32'(pad_clk), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(buttons_valid), 32'd0);
    check_eq("rst_buttons", {p2_buttons, p1_buttons}, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    reset_btn = 1'b1;

    // Idle lines, then two fixed patterns, then random words.
    run_poll(16'hFFFF, 16'hFFFF);
    run_poll(16'hFFFE, 16'h7FFF);
    for (int k = 0; k < 2; k++) run_poll(16'($urandom), 16'($urandom));

    // poll_now held across a whole poll starts exactly one poll.
    w1 = 16'($urandom) & 16'hFF7F;
    w2 = 16'($urandom) & 16'hFF7F;
    word1 = w1;
    word2 = w2;
    exp_q.push_back({~w2, ~w1});
    vc = valid_cnt;
    @(negedge clock) poll_now = 1'b1;
    @(negedge clock);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clock);
    end
    poll_now = 1'b0;
    check_eq("held_poll_cycles", n, POLL_LEN);
    busy_seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (busy) busy_seen++;
    end
    check_eq("held_no_repoll", busy_seen, 0);
    check_eq("held_valid_count", valid_cnt, vc + 1);

    // Reset during bit 7 aborts the poll and clears the words at once.
    word1 = 16'h1234;
    word2 = 16'hABCD;
    exp_q.push_back({~word2, ~word1});
    vc = valid_cnt;
    @(negedge clock) poll_now = 1'b1;
    @(negedge clock) poll_now = 1'b0;
    n = 0; falls = 0; prev_clk = 1'b1;
    while (falls < 8 && n < 1000) begin
      if (prev_clk && !pad_clk) falls++;
      prev_clk = pad_clk;
      n++;
      if (falls < 8) @(negedge clock);
    end
    check_eq("abort_reached_bit7", falls, 8);
    #2 reset_btn = 1'b0;
    #1;
    check_eq("abort_latch", 32'(pad_latch), 32'd0);
    check_eq("abort_clk", 32'(pad_clk), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_buttons", {p2_buttons, p1_buttons}, 32'd0);
    check_eq("abort_state", 32'(dbg_state), 32'd0);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clock);
    check_eq("abort_no_valid", valid_cnt, vc);
    reset_btn = 1'b1;

    // p1_data changes one cycle before each sample edge: the level two cycles
    // before the edge is the one captured.
    a = 16'($urandom);
    word2 = 16'($urandom);
    exp_q.push_back({~word2, ~a});
    ovr_val = 1'b1;
    ovr = 1'b1;
    @(negedge clock) poll_now = 1'b1;
    @(negedge clock) poll_now = 1'b0;
    for (int j = 0; j < POLL_LEN; j++) begin
      int r;
      r = j + 1 - (2 * HALF + 2);
      if (r < 0) ovr_val = 1'b1;
      else if (r % (2 * HALF) == 0) ovr_val = a[r / (2 * HALF)];
      else ovr_val = ~a[r / (2 * HALF)];
      @(negedge clock);
    end
    ovr = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clock);
    end
    check_eq("toggle_poll_ended", n, 0);

    // Automatic polls: first POLL cycles after release, then every POLL cycles.
    reset_btn = 1'b0;
    word1 = 16'($urandom);
    word2 = 16'($urandom);
    exp_q.push_back({~word2, ~word1});
    exp_q.push_back({~word2, ~word1});
    vc = valid_cnt;
    repeat (3) @(negedge clock);
    reset_btn = 1'b1;
    n = 0;
    while (!busy && n < 1000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq("auto_first_start", n, POLL);
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clock);
      #1;
      n++;
    end
    while (!busy && n < 1000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq("auto_period", n, POLL);
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check_eq("auto_valid_count", valid_cnt, vc + 2);
    reset_btn = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("exp_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
